led_matrix_frame_shifter: RTL and testbench

- Upstream feeder for the 8x8 LED matrix driver.
- Collects one 64-bit frame as eight column bytes over a valid/ready byte interface and double-buffers it.
- Serialises the frame onto the driver's three-wire input (data, data clock, strobe). The outputs connect directly to driver inputs ui_in[0], ui_in[1] and ui_in[2].
- Generates all serial timing from the system clock, so the driver chain always sees a clean, fully shifted frame before the latch.

---
 rtl/led_matrix_frame_shifter.sv | 159 +++++++++++++++
 tb/tb_led_matrix_frame_shifter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_frame_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : led_matrix_frame_shifter                                         |
// | Brief   : Double-buffered 64-bit frame loader and 3-wire serialiser        |
// |           (sdata/sclk/strobe) feeding the 8x8 LED matrix driver.           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module led_matrix_frame_shifter #(
    parameter int CLK_DIV    = 4,
    parameter int STROBE_LEN = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       sdata,
    output logic       sclk,
    output logic       strobe,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] c_STB_LAST = 8'(STROBE_LEN - 1);

    typedef enum logic [2:0] {
        c_IDLE     = 3'd0,
        c_SHIFT_LO = 3'd1,
        c_SHIFT_HI = 3'd2,
        c_GAP      = 3'd3,
        c_STROBE   = 3'd4
    } state_t;

    state_t      r_state;
    logic [63:0] r_load;
    logic [63:0] r_shift;
    logic [3:0]  r_ld_cnt;
    logic [5:0]  r_idx;
    logic [7:0]  r_tmr;
    logic        r_active;
    logic        r_sdata;
    logic        r_sclk;
    logic        r_strobe;
    logic        r_busy;
    logic        r_done;

    logic        w_full;
    logic        w_accept;
    logic        w_xfer;

    // r_active keeps byte_ready low until the first edge out of reset
    assign w_full     = r_ld_cnt[3];
    assign byte_ready = r_active && !w_full;
    assign w_accept   = byte_valid && byte_ready;
    assign w_xfer     = w_full && (r_state == c_IDLE);

    assign sdata      = r_sdata;
    assign sclk       = r_sclk;
    assign strobe     = r_strobe;
    assign busy       = r_busy;
    assign frame_done = r_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_load   <= 64'd0;
            r_shift  <= 64'd0;
            r_ld_cnt <= 4'd0;
            r_idx    <= 6'd0;
            r_tmr    <= 8'd0;
            r_active <= 1'b0;
            r_sdata  <= 1'b0;
            r_sclk   <= 1'b0;
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_active <= 1'b1;
            r_done   <= 1'b0;

            if (w_accept) begin
                r_load[{r_ld_cnt[2:0], 3'b000} +: 8] <= byte_in;
                r_ld_cnt <= r_ld_cnt + 4'd1;
            end else if (w_xfer) begin
                r_ld_cnt <= 4'd0;
            end

            // Outputs are set alongside the state they belong to
            case (r_state)
                c_IDLE: begin
                    if (w_xfer) begin
                        r_shift <= r_load;
                        r_idx   <= 6'd63;
                        r_tmr   <= 8'd0;
                        r_sdata <= r_load[63];
                        r_busy  <= 1'b1;
                        r_state <= c_SHIFT_LO;
                    end
                end
                c_SHIFT_LO: begin
                    if (r_tmr == c_DIV_LAST) begin
                        r_tmr   <= 8'd0;
                        r_sclk  <= 1'b1;
                        r_state <= c_SHIFT_HI;
                    end else begin
                        r_tmr <= r_tmr + 8'd1;
                    end
                end
                c_SHIFT_HI: begin
                    if (r_tmr == c_DIV_LAST) begin
                        r_tmr  <= 8'd0;
                        r_sclk <= 1'b0;
                        if (r_idx != 6'd0) begin
                            r_idx   <= r_idx - 6'd1;
                            r_sdata <= r_shift[r_idx - 6'd1];
                            r_state <= c_SHIFT_LO;
                        end else begin
                            r_sdata <= 1'b0;
                            r_state <= c_GAP;
                        end
                    end else begin
                        r_tmr <= r_tmr + 8'd1;
                    end
                end
                c_GAP: begin
                    if (r_tmr == c_DIV_LAST) begin
                        r_tmr    <= 8'd0;
                        r_strobe <= 1'b1;
                        r_state  <= c_STROBE;
                    end else begin
                        r_tmr <= r_tmr + 8'd1;
                    end
                end
                c_STROBE: begin
                    if (r_tmr == c_STB_LAST) begin
                        r_tmr    <= 8'd0;
                        r_strobe <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= c_IDLE;
                    end else begin
                        r_tmr <= r_tmr + 8'd1;
                    end
                end
                default: begin
                    r_tmr    <= 8'd0;
                    r_sdata  <= 1'b0;
                    r_sclk   <= 1'b0;
                    r_strobe <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_frame_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_led_matrix_frame_shifter                                      |
// | Brief   : Directed self-checking bench for led_matrix_frame_shifter        |
// |           (CLK_DIV=2, STROBE_LEN=3).                                       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_led_matrix_frame_shifter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] byte_in = 8'd0;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic       sdata;
    logic       sclk;
    logic       strobe;
    logic       busy;
    logic       frame_done;

    int n_cmp = 0;
    int n_err = 0;

    led_matrix_frame_shifter #(
        .CLK_DIV    (2),
        .STROBE_LEN (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .sdata      (sdata),
        .sclk       (sclk),
        .strobe     (strobe),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Line monitor: cumulative counters, read by the stimulus block only
    logic [63:0] cap = 64'd0;
    int cyc = 0, rises = 0, busy_cyc = 0, fd_cnt = 0, stb_cyc = 0;
    int last_rise = -100, last_fall = 0, stb_rise = 0, stab = 0;
    int setup_viol = 0, hold_viol = 0, per_viol = 0, both_hi = 0;
    logic p_sclk = 1'b0, p_sdata = 1'b0, p_strobe = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (sdata !== p_sdata) begin
            if (sclk) hold_viol = hold_viol + 1;
            stab = 1;
        end else begin
            stab = stab + 1;
        end
        if (sclk && !p_sclk) begin
            rises = rises + 1;
            cap   = {cap[62:0], sdata};
            if (stab < 3) setup_viol = setup_viol + 1;
            if ((cyc - last_rise) < 8 && (cyc - last_rise) != 4) per_viol = per_viol + 1;
            last_rise = cyc;
        end
        if (!sclk && p_sclk) last_fall = cyc;
        if (strobe && !p_strobe) stb_rise = cyc;
        if (busy) busy_cyc = busy_cyc + 1;
        if (frame_done) fd_cnt = fd_cnt + 1;
        if (strobe) stb_cyc = stb_cyc + 1;
        if (sclk && strobe) both_hi = both_hi + 1;
        p_sclk   = sclk;
        p_sdata  = sdata;
        p_strobe = strobe;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && t < 2000) begin
            tick();
            t++;
        end
        if (t >= 2000) chk("send_timeout", 64'(t), 64'd0);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic wait_fd(input string tag);
        int t;
        t = 0;
        while (!frame_done && t < 3000) begin
            tick();
            t++;
        end
        if (t >= 3000) chk(tag, 64'(t), 64'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_sdata"}, 64'(sdata), 64'd0);
        chk({tag, "_sclk"}, 64'(sclk), 64'd0);
        chk({tag, "_strobe"}, 64'(strobe), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        chk({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
    endtask

    initial begin
        int s_rise, s_busy, s_fd, s_stb, t, rdy_seen;
        logic [7:0] fa [8];
        logic [7:0] fd_bytes [8];

        // Reset values
        repeat (3) tick();
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        chk("ready_before_edge", 64'(byte_ready), 64'd0);
        tick();
        chk("ready_after_release", 64'(byte_ready), 64'd1);

        // Single frame
        s_rise = rises; s_busy = busy_cyc; s_fd = fd_cnt; s_stb = stb_cyc;
        for (int i = 0; i < 8; i++) send_byte(8'(1 << i));
        chk("ready_full", 64'(byte_ready), 64'd0);
        tick();
        chk("ready_after_xfer", 64'(byte_ready), 64'd1);
        chk("busy_after_xfer", 64'(busy), 64'd1);
        wait_fd("fd1_timeout");
        chk("f1_rises", 64'(rises - s_rise), 64'd64);
        chk("f1_data", cap, 64'h8040201008040201);
        chk("f1_busy_cycles", 64'(busy_cyc - s_busy), 64'd261);
        chk("f1_frame_done", 64'(fd_cnt - s_fd), 64'd1);
        chk("f1_strobe_cycles", 64'(stb_cyc - s_stb), 64'd3);
        chk("f1_strobe_delay", 64'(stb_rise - last_fall), 64'd2);
        tick();
        chk("f1_fd_single", 64'(frame_done), 64'd0);

        // Overlapped loading: frame A, then all-0xFF frame B during A's shift
        fa = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        for (int i = 0; i < 8; i++) send_byte(fa[i]);
        tick();
        for (int i = 0; i < 8; i++) send_byte(8'hFF);
        byte_in = 8'hAA;
        byte_valid = 1'b1;
        rdy_seen = 0;
        t = 0;
        while (!frame_done && t < 3000) begin
            if (byte_ready) rdy_seen++;
            tick();
            t++;
        end
        chk("fdA_timeout", 64'(t >= 3000), 64'd0);
        chk("stall_ready_seen", 64'(rdy_seen), 64'd0);
        chk("fdA_data", cap, 64'hF0DEBC9A78563412);
        chk("fdA_busy", 64'(busy), 64'd0);
        chk("fdA_ready", 64'(byte_ready), 64'd0);
        s_rise = rises;
        tick();
        chk("b2b_busy", 64'(busy), 64'd1);
        chk("b2b_sclk", 64'(sclk), 64'd0);
        chk("b2b_ready", 64'(byte_ready), 64'd1);
        tick();
        byte_valid = 1'b0;
        wait_fd("fdB_timeout");
        chk("fB_rises", 64'(rises - s_rise), 64'd64);
        chk("fB_data", cap, 64'hFFFFFFFFFFFFFFFF);
        tick();

        // Partial load: 0xAA already held, four more make five
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        s_rise = rises; s_busy = busy_cyc;
        repeat (500) tick();
        chk("partial_rises", 64'(rises - s_rise), 64'd0);
        chk("partial_busy_cycles", 64'(busy_cyc - s_busy), 64'd0);
        chk("partial_ready", 64'(byte_ready), 64'd1);

        // Mid-shift reset at bit 30 (34th bit sent)
        s_fd = fd_cnt; s_stb = stb_cyc;
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
        s_rise = rises;
        t = 0;
        while ((rises - s_rise) < 34 && t < 3000) begin
            tick();
            t++;
        end
        chk("midreset_timeout", 64'(t >= 3000), 64'd0);
        chk("midreset_partial_bits", {30'd0, cap[33:0]}, 64'h77665544332211AA >> 30);
        rst_n = 1'b0;
        tick();
        chk_zero_outputs("midreset");
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("midreset_no_fd", 64'(fd_cnt - s_fd), 64'd0);
        chk("midreset_no_strobe", 64'(stb_cyc - s_stb), 64'd0);
        chk("midreset_idle", 64'(busy), 64'd0);

        fd_bytes = '{8'hC3, 8'h5A, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'h24, 8'h99};
        s_rise = rises;
        for (int i = 0; i < 8; i++) send_byte(fd_bytes[i]);
        wait_fd("fdD_timeout");
        chk("fD_rises", 64'(rises - s_rise), 64'd64);
        chk("fD_data", cap, 64'h99247E81F00F5AC3);

        // Line timing observed across the whole run
        chk("setup_violations", 64'(setup_viol), 64'd0);
        chk("hold_violations", 64'(hold_viol), 64'd0);
        chk("sclk_period_violations", 64'(per_viol), 64'd0);
        chk("sclk_strobe_overlap", 64'(both_hi), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
